tlul_xbar_1ton: RTL and testbench

TLUL_XBAR_1TON -- requirements
Module: tlul_xbar_1ton

---
 rtl/tlul_xbar_pkg.sv | 54 +++++
 rtl/tlul_xbar_1ton_if.sv | 11 +
 rtl/tlul_err_resp.sv | 69 ++++++
 rtl/tlul_xbar_1ton.sv | 117 +++++++++++
 tb/tb_tlul_xbar_1ton.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlul_xbar_pkg.sv
// Shared TL-UL types and constants for the 1:N crossbar and its error responder.
// Contents: A/D channel structs, opcode encodings, error-response constants,
// the error-responder state enum, and the target-index width helper.
package tlul_xbar_pkg;

  // A-channel opcodes
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  // D-channel opcodes
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  // Fixed fields returned for accesses that hit no device
  localparam logic [31:0] ErrRspData  = 32'hFFFF_FFFF;
  localparam logic [2:0]  ErrRspParam = 3'h0;
  localparam logic        ErrRspSink  = 1'b0;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  typedef enum logic {
    ErrEmpty = 1'b0,
    ErrFull  = 1'b1
  } err_state_e;

  // Target index spans devices 0..num_dev-1 plus the error responder at num_dev.
  function automatic int tgt_idx_w(int num_dev);
    return $clog2(num_dev + 1);
  endfunction

endpackage

// File: rtl/tlul_xbar_1ton_if.sv
// One TL-UL link (request struct + response struct).
// Modports: master drives requests and receives responses; slave the reverse.
interface tlul_xbar_1ton_if;
  import tlul_xbar_pkg::*;

  tl_h2d_t h2d;
  tl_d2h_t d2h;

  modport master (output h2d, input d2h);
  modport slave  (input h2d, output d2h);
endinterface

// File: rtl/tlul_err_resp.sv
// Single-entry TL-UL error responder for unmapped addresses.
// Ports: clk_i, rst_ni (async, active-low), tl (slave side of one TL-UL link).
// Accepts only when empty; answers the next cycle with d_error set and holds
// the response until d_ready.
module tlul_err_resp
  import tlul_xbar_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  tlul_xbar_1ton_if.slave  tl
);

  err_state_e state_q, state_d;
  logic       accept;
  logic [7:0] src_q;
  logic [1:0] size_q;
  logic       is_get_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ErrEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ErrEmpty: begin
        if (tl.h2d.a_valid) begin
          accept  = 1'b1;
          state_d = ErrFull;
        end
      end
      ErrFull: begin
        if (tl.h2d.d_ready) begin
          state_d = ErrEmpty;
        end
      end
      default: state_d = ErrEmpty;
    endcase
  end

  // Captured request fields are only meaningful while full, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      src_q    <= tl.h2d.a_source;
      size_q   <= tl.h2d.a_size;
      is_get_q <= (tl.h2d.a_opcode == Get);
    end
  end

  // Outputs depend only on registered state, keeping the crossbar path acyclic.
  assign tl.d2h.a_ready  = (state_q == ErrEmpty);
  assign tl.d2h.d_valid  = (state_q == ErrFull);
  assign tl.d2h.d_opcode = is_get_q ? AccessAckData : AccessAck;
  assign tl.d2h.d_param  = ErrRspParam;
  assign tl.d2h.d_size   = size_q;
  assign tl.d2h.d_source = src_q;
  assign tl.d2h.d_sink   = ErrRspSink;
  assign tl.d2h.d_data   = ErrRspData;
  assign tl.d2h.d_error  = 1'b1;

  logic unused_h2d;
  assign unused_h2d = ^{tl.h2d.a_param, tl.h2d.a_address, tl.h2d.a_mask, tl.h2d.a_data};

endmodule

// File: rtl/tlul_xbar_1ton.sv
// TL-UL 1-to-N crossbar: one host, NumDev devices plus an internal error responder.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   h2d_i / d2h_o       host request in / host response out
//   h2d_dev_o[NumDev]   per-device request out
//   d2h_dev_i[NumDev]   per-device response in
// Zero-latency pass-through on A and D. All in-flight requests go to one
// target (sel_q), so responses can never be reordered.
module tlul_xbar_1ton
  import tlul_xbar_pkg::*;
#(
  parameter int unsigned NumDev         = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [NumDev-1:0][31:0] DevBase =
    {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
  parameter logic [NumDev-1:0][31:0] DevMask = {NumDev{32'hFFFF_0000}}
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t h2d_i,
  output tl_d2h_t d2h_o,
  output tl_h2d_t h2d_dev_o [NumDev],
  input  tl_d2h_t d2h_dev_i [NumDev]
);

  if (NumDev < 1 || NumDev > 8) begin : g_bad_numdev
    $error("tlul_xbar_1ton: NumDev must be in 1..8");
  end
  if (MaxOutstanding < 1 || MaxOutstanding > 15) begin : g_bad_maxout
    $error("tlul_xbar_1ton: MaxOutstanding must be in 1..15");
  end

  localparam int TgtW = tgt_idx_w(NumDev);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [TgtW-1:0] ErrIdx = TgtW'(NumDev);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  // Index NumDev of these arrays is the error responder.
  tl_h2d_t h2d_all [NumDev+1];
  tl_d2h_t d2h_all [NumDev+1];

  logic [TgtW-1:0] tgt, sel_q, sel_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            a_gate, a_fire, d_fire;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    tgt = ErrIdx;
    for (int i = int'(NumDev) - 1; i >= 0; i--) begin
      if ((h2d_i.a_address & DevMask[i]) == DevBase[i]) begin
        tgt = TgtW'(i);
      end
    end
  end

  // Switching targets waits until every outstanding response has returned.
  assign a_gate = rst_ni && d2h_all[tgt].a_ready && (cnt_q < CntMax) &&
                  ((cnt_q == '0) || (tgt == sel_q));
  assign a_fire = h2d_i.a_valid && a_gate;
  assign d_fire = (cnt_q != '0) && d2h_all[sel_q].d_valid && h2d_i.d_ready;

  always_comb begin
    for (int i = 0; i < int'(NumDev) + 1; i++) begin
      h2d_all[i]         = h2d_i;
      h2d_all[i].a_valid = a_fire && (TgtW'(i) == tgt);
      h2d_all[i].d_ready = h2d_i.d_ready && (TgtW'(i) == sel_q);
    end
  end

  for (genvar g = 0; g < NumDev; g++) begin : g_dev
    assign h2d_dev_o[g] = h2d_all[g];
    assign d2h_all[g]   = d2h_dev_i[g];
  end

  tlul_xbar_1ton_if err_if ();
  assign err_if.h2d      = h2d_all[NumDev];
  assign d2h_all[NumDev] = err_if.d2h;

  tlul_err_resp u_err_resp (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tl     (err_if)
  );

  // With nothing in flight the D channel is idle regardless of device outputs.
  always_comb begin
    d2h_o = '0;
    if (cnt_q != '0) begin
      d2h_o = d2h_all[sel_q];
    end
    d2h_o.a_ready = a_gate;
  end

  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (a_fire) begin
      sel_d = tgt;
    end
    case ({a_fire, d_fire})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

endmodule

// File: tb/tb_tlul_xbar_1ton.sv
`timescale 1ns/1ps
module tb_tlul_xbar_1ton;
  import tlul_xbar_pkg::*;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tlul_xbar_1ton_if host_if ();
  tl_h2d_t dev_h2d [ND];
  tl_d2h_t dev_d2h [ND];

  // Second instance with dev0/dev1 overlapping at 0x1000_0000.
  tl_h2d_t ov_h2d [ND];
  tl_d2h_t ov_d2h [ND];
  tl_d2h_t ov_host_d2h;

  tlul_xbar_1ton #(.NumDev(ND), .MaxOutstanding(4)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .h2d_i     (host_if.h2d),
    .d2h_o     (host_if.d2h),
    .h2d_dev_o (dev_h2d),
    .d2h_dev_i (dev_d2h)
  );

  tlul_xbar_1ton #(
    .NumDev(ND), .MaxOutstanding(4),
    .DevBase({32'h4000_0000, 32'h3000_0000, 32'h1000_0000, 32'h1000_0000}),
    .DevMask({32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hFFFF_0000})
  ) dut_ov (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .h2d_i     (host_if.h2d),
    .d2h_o     (ov_host_d2h),
    .h2d_dev_o (ov_h2d),
    .d2h_dev_i (ov_d2h)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put_a(input logic v, input logic [2:0] op, input logic [31:0] addr,
                       input logic [7:0] src, input logic [1:0] sz);
    host_if.h2d.a_valid   = v;
    host_if.h2d.a_opcode  = op;
    host_if.h2d.a_param   = 3'h0;
    host_if.h2d.a_size    = sz;
    host_if.h2d.a_source  = src;
    host_if.h2d.a_address = addr;
    host_if.h2d.a_mask    = 4'hF;
    host_if.h2d.a_data    = {24'h0, src};
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  src;
    int          exp_dev;  // ND means error responder
    int          exp_ov;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{32'h1000_0000, 8'd1, 0, 0};
    vt[1] = '{32'h1000_FFFC, 8'd2, 0, 0};
    vt[2] = '{32'h2000_0010, 8'd3, 1, 4};
    vt[3] = '{32'h3000_ABCD, 8'd4, 2, 2};
    vt[4] = '{32'h4000_FFFF, 8'd5, 3, 3};
    vt[5] = '{32'h9000_0000, 8'd6, 4, 4};
    vt[6] = '{32'h1001_0000, 8'd7, 4, 1};
    vt[7] = '{32'h0000_0000, 8'd8, 4, 4};

    host_if.h2d = '0;
    for (int k = 0; k < ND; k++) begin
      dev_d2h[k] = '0;
      dev_d2h[k].a_ready = 1'b1;
      ov_d2h[k] = '0;
      ov_d2h[k].a_ready = 1'b1;
    end

    // Reset: valids must stay low even with a request presented.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    put_a(1'b1, Get, 32'h2000_0010, 8'd0, 2'd2);
    #2;
    for (int k = 0; k < ND; k++) chk("rst_dev_avalid", dev_h2d[k].a_valid, 0);
    chk("rst_host_dvalid", host_if.d2h.d_valid, 0);
    chk("rst_cnt", dut.cnt_q, 0);
    chk("rst_sel", dut.sel_q, 0);
    @(negedge clk);
    put_a(1'b0, Get, 32'h0, 8'd0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Decode table: combinational routing only, cleared before the next edge.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      put_a(1'b1, Get, vt[i].addr, vt[i].src, 2'd2);
      #1;
      chk("tbl_ardy", host_if.d2h.a_ready, 1);
      for (int k = 0; k < ND; k++) begin
        chk("tbl_route", dev_h2d[k].a_valid, (vt[i].exp_dev == k));
        chk("tbl_ov_route", ov_h2d[k].a_valid, (vt[i].exp_ov == k));
      end
      if (vt[i].exp_dev < ND) begin
        chk("tbl_addr", dev_h2d[vt[i].exp_dev].a_address, vt[i].addr);
        chk("tbl_src", dev_h2d[vt[i].exp_dev].a_source, vt[i].src);
      end
      put_a(1'b0, Get, 32'h0, 8'd0, 2'd0);
      #1;
    end

    // Back-to-back Gets to dev1 with no responses.
    @(negedge clk);
    host_if.h2d.d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put_a(1'b1, Get, 32'h2000_0010, 8'(i), 2'd2);
      #1;
      chk("b2b_ardy", host_if.d2h.a_ready, 1);
      chk("b2b_dev1_vld", dev_h2d[1].a_valid, 1);
      cyc();
    end
    chk("b2b_cnt_peak", dut.cnt_q, 4);
    #1;
    chk("b2b_5th_stall", host_if.d2h.a_ready, 0);
    chk("b2b_5th_no_vld", dev_h2d[1].a_valid, 0);
    dev_d2h[1].d_valid  = 1'b1;
    dev_d2h[1].d_opcode = AccessAckData;
    dev_d2h[1].d_data   = 32'hA5A5_0001;
    #1;
    chk("b2b_d_vld", host_if.d2h.d_valid, 1);
    chk("b2b_d_data", host_if.d2h.d_data, 32'hA5A5_0001);
    chk("b2b_still_stall", host_if.d2h.a_ready, 0);
    cyc();
    dev_d2h[1].d_valid = 1'b0;
    #1;
    chk("b2b_cnt_after_d", dut.cnt_q, 3);
    chk("b2b_5th_ardy", host_if.d2h.a_ready, 1);
    cyc();
    put_a(1'b0, Get, 32'h0, 8'd0, 2'd0);
    #1;
    chk("b2b_cnt_refill", dut.cnt_q, 4);

    // Drain to 2, then A and D fire together.
    dev_d2h[1].d_valid = 1'b1;
    cyc();
    cyc();
    chk("sim_cnt_pre", dut.cnt_q, 2);
    put_a(1'b1, Get, 32'h2000_0010, 8'd7, 2'd2);
    #1;
    chk("sim_ardy", host_if.d2h.a_ready, 1);
    cyc();
    put_a(1'b0, Get, 32'h0, 8'd0, 2'd0);
    #1;
    chk("sim_cnt_hold", dut.cnt_q, 2);
    cyc();
    cyc();
    dev_d2h[1].d_valid = 1'b0;
    #1;
    chk("sim_cnt_drained", dut.cnt_q, 0);

    // Switch stall: Get to dev0 outstanding, then Put to dev2.
    put_a(1'b1, Get, 32'h1000_0000, 8'd9, 2'd2);
    #1;
    chk("sw_first_ardy", host_if.d2h.a_ready, 1);
    cyc();
    put_a(1'b1, PutFullData, 32'h3000_0000, 8'd10, 2'd2);
    #1;
    chk("sw_stall_ardy", host_if.d2h.a_ready, 0);
    chk("sw_stall_dev2", dev_h2d[2].a_valid, 0);
    chk("sw_cnt1", dut.cnt_q, 1);
    cyc();
    #1;
    chk("sw_stall_ardy2", host_if.d2h.a_ready, 0);
    dev_d2h[0].d_valid  = 1'b1;
    dev_d2h[0].d_opcode = AccessAckData;
    #1;
    chk("sw_stall_during_d", host_if.d2h.a_ready, 0);
    chk("sw_d_vld", host_if.d2h.d_valid, 1);
    cyc();
    dev_d2h[0].d_valid = 1'b0;
    #1;
    chk("sw_cnt0", dut.cnt_q, 0);
    chk("sw_accept_ardy", host_if.d2h.a_ready, 1);
    chk("sw_accept_dev2", dev_h2d[2].a_valid, 1);
    cyc();
    put_a(1'b0, Get, 32'h0, 8'd0, 2'd0);
    #1;
    chk("sw_cnt_new", dut.cnt_q, 1);
    chk("sw_sel_new", dut.sel_q, 2);
    dev_d2h[2].d_valid  = 1'b1;
    dev_d2h[2].d_opcode = AccessAck;
    cyc();
    dev_d2h[2].d_valid = 1'b0;
    #1;
    chk("sw_drained", dut.cnt_q, 0);

    // Unmapped Get, source 5.
    put_a(1'b1, Get, 32'h9000_0000, 8'd5, 2'd2);
    #1;
    chk("err_ardy", host_if.d2h.a_ready, 1);
    chk("err_d_not_yet", host_if.d2h.d_valid, 0);
    for (int k = 0; k < ND; k++) chk("err_no_dev_vld", dev_h2d[k].a_valid, 0);
    cyc();
    put_a(1'b1, PutFullData, 32'h9000_0004, 8'd6, 2'd1);
    host_if.h2d.d_ready = 1'b0;
    #1;
    chk("err_d_vld", host_if.d2h.d_valid, 1);
    chk("err_d_error", host_if.d2h.d_error, 1);
    chk("err_d_data", host_if.d2h.d_data, 32'hFFFF_FFFF);
    chk("err_d_source", host_if.d2h.d_source, 5);
    chk("err_d_opcode", host_if.d2h.d_opcode, 1);
    chk("err_d_size", host_if.d2h.d_size, 2);
    chk("err_d_param", host_if.d2h.d_param, 0);
    chk("err_d_sink", host_if.d2h.d_sink, 0);
    chk("err_full_ardy", host_if.d2h.a_ready, 0);
    cyc();
    #1;
    chk("err_hold_vld", host_if.d2h.d_valid, 1);
    chk("err_hold_ardy", host_if.d2h.a_ready, 0);
    host_if.h2d.d_ready = 1'b1;
    cyc();
    #1;
    chk("err_cnt0", dut.cnt_q, 0);
    chk("err_put_ardy", host_if.d2h.a_ready, 1);
    cyc();
    put_a(1'b0, Get, 32'h0, 8'd0, 2'd0);
    #1;
    chk("err_put_vld", host_if.d2h.d_valid, 1);
    chk("err_put_opcode", host_if.d2h.d_opcode, 0);
    chk("err_put_source", host_if.d2h.d_source, 6);
    chk("err_put_size", host_if.d2h.d_size, 1);
    cyc();
    #1;
    chk("err_put_drained", dut.cnt_q, 0);
    chk("err_put_dvld0", host_if.d2h.d_valid, 0);

    // Mid-operation reset with three in flight.
    for (int i = 0; i < 3; i++) begin
      put_a(1'b1, Get, 32'h2000_0010, 8'(i), 2'd2);
      cyc();
    end
    #1;
    chk("mrst_cnt3", dut.cnt_q, 3);
    dev_d2h[1].d_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mrst_cnt0", dut.cnt_q, 0);
    chk("mrst_host_dvld", host_if.d2h.d_valid, 0);
    for (int k = 0; k < ND; k++) chk("mrst_dev_avld", dev_h2d[k].a_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dev_d2h[1].d_valid = 1'b0;
    #1;
    chk("mrst_ardy", host_if.d2h.a_ready, 1);
    chk("mrst_dev1_vld", dev_h2d[1].a_valid, 1);
    cyc();
    put_a(1'b0, Get, 32'h0, 8'd0, 2'd0);
    #1;
    chk("mrst_cnt1", dut.cnt_q, 1);
    dev_d2h[1].d_valid = 1'b1;
    cyc();
    dev_d2h[1].d_valid = 1'b0;
    #1;
    chk("mrst_drained", dut.cnt_q, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
